// File: rtl/sel_scan_pkg.sv
// Shared types and helpers for the 4-channel select scanner.
package sel_scan_pkg;

    localparam int NCH  = 4;
    localparam int CH_W = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    function automatic logic [NCH-1:0] onehot4(input logic [CH_W-1:0] ch);
        logic [NCH-1:0] oh;
        oh     = '0;
        oh[ch] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/sel_scan_ctrl_rr_pick4.sv
// Round-robin picker: searches ptr+1, ptr+2, ptr+3, ptr and returns the first requester.
module rr_pick4
    import sel_scan_pkg::*;
(
    input  logic [NCH-1:0]  req,
    input  logic [CH_W-1:0] ptr,
    output logic            found,
    output logic [CH_W-1:0] win
);

    always_comb begin
        logic [CH_W-1:0] idx;
        found = 1'b0;
        win   = ptr;
        idx   = ptr;
        // Walk from lowest to highest priority so the highest-priority hit is written last.
        for (int i = NCH; i >= 1; i--) begin
            idx = ptr + CH_W'(i);
            if (req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

endmodule

// File: rtl/sel_scan_ctrl.sv
// Round-robin scan controller for a downstream 4:1 mux; each grant is held DWELL cycles.
// Optional sample path of the mux output is built when SEL_SCAN_SAMPLE_EN is defined.
module sel_scan_ctrl
    import sel_scan_pkg::*;
#(
    parameter int DWELL = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [3:0] req,
    output logic [1:0] s,
    output logic [3:0] grant,
    output logic       busy,
    input  logic       y,
    output logic       smp_data,
    output logic [1:0] smp_ch,
    output logic       smp_valid
);

    localparam int               CNT_W    = 4;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DWELL - 1);

    state_t           state_q, state_d;
    logic [CH_W-1:0]  s_q, s_d;
    logic [NCH-1:0]   grant_q, grant_d;
    logic             busy_q, busy_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CH_W-1:0]  ptr_q, ptr_d;

    logic             pick_found;
    logic [CH_W-1:0]  pick_win;

    rr_pick4 u_pick (
        .req   (req),
        .ptr   (ptr_q),
        .found (pick_found),
        .win   (pick_win)
    );

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        grant_d = grant_q;
        busy_d  = busy_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (en && pick_found) begin
                    state_d = GRANT;
                    s_d     = pick_win;
                    grant_d = onehot4(pick_win);
                    busy_d  = 1'b1;
                    cnt_d   = CNT_LOAD;
                    ptr_d   = pick_win;
                end
            end
            GRANT: begin
                if (!en) begin
                    state_d = IDLE;
                    grant_d = '0;
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    if (pick_found) begin
                        s_d     = pick_win;
                        grant_d = onehot4(pick_win);
                        cnt_d   = CNT_LOAD;
                        ptr_d   = pick_win;
                    end else begin
                        state_d = IDLE;
                        grant_d = '0;
                        busy_d  = 1'b0;
                    end
                end else if (!req[s_q]) begin
                    // Requester withdrew: make the next cycle the last dwell cycle.
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            s_q     <= '0;
            grant_q <= '0;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            ptr_q   <= 2'd3;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            grant_q <= grant_d;
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
        end
    end

    assign s     = s_q;
    assign grant = grant_q;
    assign busy  = busy_q;

`ifdef SEL_SCAN_SAMPLE_EN
    logic            smp_data_q, smp_data_d;
    logic [CH_W-1:0] smp_ch_q, smp_ch_d;
    logic            smp_valid_q, smp_valid_d;

    // Capture on the last dwell cycle; early ends are folded into cnt=0 above.
    always_comb begin
        smp_data_d  = smp_data_q;
        smp_ch_d    = smp_ch_q;
        smp_valid_d = 1'b0;
        if (state_q == GRANT && cnt_q == '0) begin
            smp_data_d  = y;
            smp_ch_d    = s_q;
            smp_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            smp_data_q  <= 1'b0;
            smp_ch_q    <= '0;
            smp_valid_q <= 1'b0;
        end else begin
            smp_data_q  <= smp_data_d;
            smp_ch_q    <= smp_ch_d;
            smp_valid_q <= smp_valid_d;
        end
    end

    assign smp_data  = smp_data_q;
    assign smp_ch    = smp_ch_q;
    assign smp_valid = smp_valid_q;
`else
    logic unused_y;
    assign unused_y  = y;
    assign smp_data  = 1'b0;
    assign smp_ch    = '0;
    assign smp_valid = 1'b0;
`endif

endmodule

// File: tb/tb_sel_scan_ctrl.sv
// Directed bench for sel_scan_ctrl: a DWELL=4 instance and a DWELL=2 instance share stimulus.
module tb_sel_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst, en, y;
    logic [3:0] req;

    logic [1:0] s4, s2, ch4, ch2;
    logic [3:0] g4, g2;
    logic       b4, b2, d4, d2, v4, v2;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    sel_scan_ctrl #(.DWELL(4)) u4 (
        .clk(clk), .rst(rst), .en(en), .req(req), .s(s4), .grant(g4), .busy(b4),
        .y(y), .smp_data(d4), .smp_ch(ch4), .smp_valid(v4)
    );

    sel_scan_ctrl #(.DWELL(2)) u2 (
        .clk(clk), .rst(rst), .en(en), .req(req), .s(s2), .grant(g2), .busy(b2),
        .y(y), .smp_data(d2), .smp_ch(ch2), .smp_valid(v2)
    );

    typedef struct {
        logic       rst;
        logic       en;
        logic [3:0] req;
        logic [1:0] s;
        logic [3:0] g;
        logic       b;
    } vec_t;

    vec_t tbl[25];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; req = 4'h0; y = 1'b0;

        //           rst  en    req    s     grant  busy
        tbl[0]  = '{1'b1, 1'b1, 4'hF, 2'd0, 4'h0, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 4'h5, 2'd0, 4'h1, 1'b1};
        tbl[2]  = '{1'b0, 1'b1, 4'h5, 2'd0, 4'h1, 1'b1};
        tbl[3]  = '{1'b0, 1'b1, 4'h5, 2'd0, 4'h1, 1'b1};
        tbl[4]  = '{1'b0, 1'b1, 4'h5, 2'd0, 4'h1, 1'b1};
        tbl[5]  = '{1'b0, 1'b1, 4'h5, 2'd2, 4'h4, 1'b1};
        tbl[6]  = '{1'b0, 1'b1, 4'h5, 2'd2, 4'h4, 1'b1};
        tbl[7]  = '{1'b0, 1'b1, 4'h5, 2'd2, 4'h4, 1'b1};
        tbl[8]  = '{1'b0, 1'b1, 4'h5, 2'd2, 4'h4, 1'b1};
        tbl[9]  = '{1'b0, 1'b1, 4'h5, 2'd0, 4'h1, 1'b1};
        tbl[10] = '{1'b0, 1'b1, 4'h5, 2'd0, 4'h1, 1'b1};
        tbl[11] = '{1'b0, 1'b1, 4'h5, 2'd0, 4'h1, 1'b1};
        tbl[12] = '{1'b0, 1'b1, 4'h5, 2'd0, 4'h1, 1'b1};
        tbl[13] = '{1'b0, 1'b1, 4'h5, 2'd2, 4'h4, 1'b1};
        tbl[14] = '{1'b0, 1'b0, 4'h5, 2'd2, 4'h0, 1'b0};
        tbl[15] = '{1'b0, 1'b0, 4'h5, 2'd2, 4'h0, 1'b0};
        tbl[16] = '{1'b0, 1'b1, 4'hF, 2'd3, 4'h8, 1'b1};
        tbl[17] = '{1'b1, 1'b1, 4'hF, 2'd0, 4'h0, 1'b0};
        tbl[18] = '{1'b0, 1'b1, 4'h2, 2'd1, 4'h2, 1'b1};
        tbl[19] = '{1'b0, 1'b1, 4'h2, 2'd1, 4'h2, 1'b1};
        tbl[20] = '{1'b0, 1'b1, 4'h4, 2'd1, 4'h2, 1'b1};
        tbl[21] = '{1'b0, 1'b1, 4'h4, 2'd2, 4'h4, 1'b1};
        tbl[22] = '{1'b0, 1'b1, 4'h0, 2'd2, 4'h4, 1'b1};
        tbl[23] = '{1'b0, 1'b1, 4'h0, 2'd2, 4'h0, 1'b0};
        tbl[24] = '{1'b0, 1'b1, 4'h0, 2'd2, 4'h0, 1'b0};

        #2;
        for (int i = 0; i < 25; i++) begin
            rst = tbl[i].rst; en = tbl[i].en; req = tbl[i].req;
            tick();
            chk($sformatf("v%0d_s", i), s4, tbl[i].s);
            chk($sformatf("v%0d_grant", i), g4, tbl[i].g);
            chk($sformatf("v%0d_busy", i), b4, tbl[i].b);
        end

        // Sole requester ch3 with DWELL=2 is re-granted with no gap.
        rst = 1'b1; en = 1'b1; req = 4'h8;
        tick();
        chk("d2_rst_busy", b2, 0);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk($sformatf("d2_solo%0d_s", i), s2, 3);
            chk($sformatf("d2_solo%0d_grant", i), g2, 8);
            chk($sformatf("d2_solo%0d_busy", i), b2, 1);
        end

        // DWELL=2 alternation between ch0 and ch2.
        rst = 1'b1; req = 4'h5;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk($sformatf("d2_alt%0d_s", i), s2, ((i / 2) % 2 == 0) ? 0 : 2);
            chk($sformatf("d2_alt%0d_busy", i), b2, 1);
        end

        // Sample of y on the last dwell cycle of ch2 (DWELL=4).
        rst = 1'b1; req = 4'h4; y = 1'b0;
        tick();
        chk("smp_rst_valid", v4, 0);
        chk("smp_rst_data", d4, 0);
        chk("smp_rst_ch", ch4, 0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("smp_pre_valid", v4, 0);
        chk("smp_pre_s", s4, 2);
        y = 1'b1;
        tick();
        y = 1'b0;
`ifdef SEL_SCAN_SAMPLE_EN
        chk("smp_valid", v4, 1);
        chk("smp_data", d4, 1);
        chk("smp_ch", ch4, 2);
`else
        chk("smp_valid", v4, 0);
        chk("smp_data", d4, 0);
        chk("smp_ch", ch4, 0);
`endif
        chk("smp_regrant_s", s4, 2);
        tick();
        chk("smp_post_valid", v4, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sel_scan_ctrl.md
SEL_SCAN_CTRL -- requirements
Module: sel_scan_ctrl

Interface
REQ-001 SHALL have parameter DWELL, default 4, legal range 1..16: cycles each grant is held.
REQ-002 SHALL have port clk, input, 1 bit: sole clock, rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port en, input, 1 bit: scan enable.
REQ-005 SHALL have port req, input, 4 bits: per-channel request, bit n = channel n.
REQ-006 SHALL have port s, output, 2 bits: select driven to the downstream 4:1 mux.
REQ-007 SHALL have port grant, output, 4 bits: one-hot copy of s while busy, else 0.
REQ-008 SHALL have port busy, output, 1 bit: a grant is active.
REQ-009 SHALL have port y, input, 1 bit: mux output fed back (used only under REQ-026).
REQ-010 SHALL have port smp_data, output, 1 bit: captured mux output.
REQ-011 SHALL have port smp_ch, output, 2 bits: channel of smp_data.
REQ-012 SHALL have port smp_valid, output, 1 bit: one-cycle pulse, sample new.

Function
REQ-013 SHALL drive all outputs from registers, with no combinational input-to-output path.
REQ-014 SHALL implement FSM states IDLE and GRANT.
- IDLE -> GRANT when en=1 and req!=0.
- GRANT -> IDLE at dwell end with no eligible request, or whenever en=0.
REQ-015 SHALL pick the winner round-robin from last pointer ptr: search ptr+1, ptr+2, ptr+3, ptr (mod 4), first set req bit wins.
REQ-016 SHALL, on entering GRANT, register s=winner, grant=1<<winner, busy=1, dwell counter cnt=DWELL-1, ptr=winner, all in the cycle after the request is seen (latency 1).
REQ-017 SHALL decrement cnt each GRANT cycle.
- At cnt=0, re-arbitrate per REQ-015 and load the new winner with cnt=DWELL-1 the next cycle, with no idle gap.
- A sole requester is re-granted.
REQ-018 SHALL end a grant early, returning to the arbitration of REQ-017 on the next cycle, if req[s] drops mid-dwell.
REQ-019 SHALL, with DWELL=1, arbitrate every cycle.
REQ-020 SHALL, on en=0, go to IDLE next cycle with busy=0 and grant=0; s and ptr hold their values.
REQ-021 SHALL hold s at its last value in IDLE so the mux output stays stable.
REQ-022 SHALL give rst priority over en and req when asserted simultaneously.

Reset
REQ-023 SHALL, on rst=1 at a clock edge, set state=IDLE, s=0, grant=0, busy=0, cnt=0, ptr=3 (first pick favours channel 0), smp_data=0, smp_ch=0, smp_valid=0.
REQ-024 SHALL abort any grant on reset mid-dwell, with no sample pulse.
REQ-025 SHALL resume normally in the cycle after rst falls.

Configuration
REQ-026 SHALL compile the sample path only with macro SEL_SCAN_SAMPLE_EN defined.
- On the last dwell cycle (cnt=0, or early end per REQ-018), capture y into smp_data and s into smp_ch.
- Pulse smp_valid=1 the following cycle.
REQ-027 SHALL, without SEL_SCAN_SAMPLE_EN, ignore y and tie smp_data, smp_ch and smp_valid to 0; the port list is unchanged.

Structure
REQ-028 SHALL take from package sel_scan_pkg: state enum (IDLE, GRANT), NCH=4, CH_W=2, and a function onehot4(ch).
REQ-029 SHALL place the arbitration of REQ-015 in a combinational sub-module rr_pick4 (inputs req, ptr; outputs found, win[1:0]).

Verification
REQ-030 SHALL verify, after reset with DWELL=4 and req=4'b0101, en=1: grants ch0 x4 cycles, ch2 x4, ch0 x4, with no gaps and s toggling 0,2,0.
REQ-031 SHALL verify, with req=4'b1000 only and DWELL=2: ch3 is re-granted continuously and busy stays 1.
REQ-032 SHALL verify, with ch1 granted and req[1] dropping at cnt=2: the next cycle arbitrates and ch2 (req=4'b0100) is granted one cycle later.
REQ-033 SHALL verify, with en dropped mid-grant: next cycle busy=0 and grant=0, s holds; en reasserted resumes from ptr+1.
REQ-034 SHALL verify, with rst=1 and en=1, req=4'hF in the same cycle: outputs are reset values and the first grant after release is ch0.
REQ-035 SHALL verify, with SEL_SCAN_SAMPLE_EN, y=1 on the last dwell cycle of ch2: the next cycle gives smp_valid=1, smp_data=1, smp_ch=2; without the macro, smp_valid stays 0.
